any1_sel_align: RTL and testbench
=================================

Name: any1_sel_align

Overview:
Parametrised byte-lane select generator and access splitter between the ANY-1 memory-stage and the data bus. It accepts one load/store request with byte address and log2 size. It emits one or two bus cycles with bus-aligned address, per-byte select, and lane-shifted write data. Accesses crossing a BUS_BYTES boundary are split into two cycles. Requests and bus cycles both use valid/ready handshakes.

Parameters:
AWID, 32, address width in bits.
BUS_BYTES, 16, bus width in bytes; power of two, 4..32.
MAX_SIZE, 4, largest legal log2 access size; must satisfy 2**MAX_SIZE <= BUS_BYTES.

Ports:
clk_i  input  1  clock, all state on rising edge.
rst_ni  input  1  asynchronous active-low reset.
req_valid_i  input  1  request present.
req_ready_o  output  1  request accepted when valid&ready.
req_we_i  input  1  1=store, 0=load.
req_adr_i  input  AWID  byte address.
req_size_i  input  3  log2 access bytes (0=1B .. MAX_SIZE).
req_dat_i  input  BUS_BYTES*8  store data, right-justified.
bus_valid_o  output  1  bus cycle present.
bus_ready_i  input  1  bus cycle taken when valid&ready.
bus_we_o  output  1  copy of req_we_i.
bus_adr_o  output  AWID  address, low log2(BUS_BYTES) bits zero.
bus_sel_o  output  BUS_BYTES  byte-lane selects.
bus_dat_o  output  BUS_BYTES*8  lane-aligned store data.
bus_last_o  output  1  final cycle of this request.
bus_seq_o  output  1  0=first cycle, 1=second cycle.
err_o  output  1  one-cycle pulse on illegal size.

Behaviour:
- Reset (async, rst_ni low): state IDLE; bus_valid_o, bus_we_o, bus_last_o, bus_seq_o, err_o = 0; bus_adr_o, bus_sel_o, bus_dat_o = 0. req_ready_o = 1 once reset deasserts.
- off = req_adr_i[log2(BUS_BYTES)-1:0]; n = 2**req_size_i.
- mask2 = ((1<<n)-1) << off, width 2*BUS_BYTES. dat2 = zero-extended req_dat_i << (off*8), width 2*BUS_BYTES*8.
- Only the low n bytes of req_dat_i are meaningful; upper store bytes are masked to zero in dat2.
- States: IDLE, FIRST, SECOND. All bus outputs are registered.
- Latency: request accepted at edge k; bus_valid_o is high from edge k (visible in cycle k+1).
- On accept with legal size:
  - bus_adr_o = req_adr_i with offset bits cleared; bus_sel_o = mask2 low half; bus_dat_o = dat2 low half; bus_seq_o = 0.
  - bus_last_o = 1 iff mask2 high half == 0.
  - State goes to FIRST. The high halves and next address are held internally.
- FIRST, bus handshake, not last: load the second cycle (adr + BUS_BYTES modulo 2**AWID, high halves, seq=1, last=1); state goes to SECOND. bus_valid_o stays high with no bubble.
- Handshake on a last cycle: bus_valid_o drops next cycle unless a new request is accepted on the same edge.
- req_ready_o = (state==IDLE) | (bus_valid_o & bus_ready_i & bus_last_o). Back-to-back single-cycle requests sustain one per clock.
- Back-pressure: while bus_valid_o & !bus_ready_i, every bus output holds stable.
- Illegal size (req_size_i > MAX_SIZE): the request is accepted and no bus cycle is generated. err_o pulses high for exactly one cycle after the accept edge. State remains or returns to IDLE.
- Address wrap: second-cycle address wraps to 0 modulo 2**AWID. No error is raised.
- Zero-offset accesses of size log2(BUS_BYTES) never split.
- Reset asserted mid-split drops the pending second cycle. After release, outputs match reset values.

Test Plan:
- BUS_BYTES=16, load size 2 at 0x1004 -> one cycle: adr 0x1000, sel 0x00F0, last=1, seq=0.
- Store size 3 at 0x100C, dat 0x8877665544332211 -> cycle 1: adr 0x1000, sel 0xF000, dat bytes 12..15 = 11,22,33,44. Cycle 2: adr 0x1010, sel 0x000F, dat bytes 0..3 = 55,66,77,88, last=1, seq=1. No idle cycle between them.
- Size 2 at 0xFFFFFFFE -> adr 0xFFFFFFF0 sel 0xC000, then adr 0x00000000 sel 0x0003, last=1.
- Misaligned split with bus_ready_i low for 3 cycles on each half -> outputs stable while stalled. req_ready_o stays 0 until the second handshake completes.
- req_size_i=5 with MAX_SIZE=4 -> req_ready_o=1, err_o high exactly one cycle, bus_valid_o stays 0.
- Four back-to-back aligned size-0 requests with bus_ready_i=1 -> four consecutive bus cycles. Sels 0x0001, 0x0002, 0x0004, 0x0008 for adr 0x0,0x1,0x2,0x3. Then rst_ni pulsed low during cycle 1 of a split -> no second cycle, all outputs at reset values.

Source files
------------

// File: rtl/any1_sel_align_if.sv
// Request and bus-cycle handshake bundle between the ANY-1 memory stage and the data bus.
interface any1_sel_align_if #(
  parameter int unsigned AWID      = 32,
  parameter int unsigned BUS_BYTES = 16
);
  logic                     req_valid_i;
  logic                     req_ready_o;
  logic                     req_we_i;
  logic [AWID-1:0]          req_adr_i;
  logic [2:0]               req_size_i;
  logic [BUS_BYTES*8-1:0]   req_dat_i;
  logic                     bus_valid_o;
  logic                     bus_ready_i;
  logic                     bus_we_o;
  logic [AWID-1:0]          bus_adr_o;
  logic [BUS_BYTES-1:0]     bus_sel_o;
  logic [BUS_BYTES*8-1:0]   bus_dat_o;
  logic                     bus_last_o;
  logic                     bus_seq_o;
  logic                     err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_adr_i, req_size_i, req_dat_i, bus_ready_i,
    output req_ready_o, bus_valid_o, bus_we_o, bus_adr_o, bus_sel_o, bus_dat_o,
           bus_last_o, bus_seq_o, err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_adr_i, req_size_i, req_dat_i, bus_ready_i,
    input  req_ready_o, bus_valid_o, bus_we_o, bus_adr_o, bus_sel_o, bus_dat_o,
           bus_last_o, bus_seq_o, err_o
  );
endinterface

// File: rtl/any1_sel_align.sv
// Byte-lane select generator and access splitter: turns one load/store request into
// one or two bus-aligned cycles, splitting accesses that cross a bus-width boundary.
module any1_sel_align #(
  parameter int unsigned AWID      = 32,
  parameter int unsigned BUS_BYTES = 16,
  parameter int unsigned MAX_SIZE  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  any1_sel_align_if.slave   bus_if
);
  localparam int unsigned OFFW = $clog2(BUS_BYTES);
  localparam int unsigned DW   = BUS_BYTES * 8;
  localparam int unsigned SW   = 2 * BUS_BYTES;
  localparam int unsigned W2   = 2 * DW;

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_e;

  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  logic                  we_q, we_d;
  logic [AWID-1:0]       adr_q, adr_d;
  logic [BUS_BYTES-1:0]  sel_q, sel_d;
  logic [DW-1:0]         dat_q, dat_d;
  logic                  last_q, last_d;
  logic                  seq_q, seq_d;
  logic                  err_q, err_d;
  logic [BUS_BYTES-1:0]  hi_sel_q, hi_sel_d;
  logic [DW-1:0]         hi_dat_q, hi_dat_d;
  logic [AWID-1:0]       nxt_adr_q, nxt_adr_d;

  logic [OFFW-1:0]       off;
  logic                  size_ok;
  logic [SW-1:0]         lanes;
  logic [SW-1:0]         mask2;
  logic [DW-1:0]         dat_m;
  logic [W2-1:0]         dat2;
  logic [AWID-1:0]       base_adr;
  logic                  hs;
  logic                  req_ready;
  logic                  accept;

  // Request decode: lane mask and store data spread over two bus words.
  always_comb begin
    off      = bus_if.req_adr_i[OFFW-1:0];
    size_ok  = (bus_if.req_size_i <= 3'(MAX_SIZE));
    lanes    = (SW'(1) << (8'd1 << bus_if.req_size_i)) - SW'(1);
    mask2    = lanes << off;
    dat_m    = '0;
    for (int i = 0; i < BUS_BYTES; i++) begin
      if (lanes[i]) dat_m[i*8 +: 8] = bus_if.req_dat_i[i*8 +: 8];
    end
    dat2     = W2'(dat_m) << {off, 3'b000};
    base_adr = {bus_if.req_adr_i[AWID-1:OFFW], OFFW'(0)};
  end

  assign hs        = valid_q & bus_if.bus_ready_i;
  assign req_ready = (state_q == IDLE) | (hs & last_q);
  assign accept    = bus_if.req_valid_i & req_ready;

  // Next state: retire or advance the current cycle, then load a newly accepted request.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    we_d      = we_q;
    adr_d     = adr_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    last_d    = last_q;
    seq_d     = seq_q;
    err_d     = 1'b0;
    hi_sel_d  = hi_sel_q;
    hi_dat_d  = hi_dat_q;
    nxt_adr_d = nxt_adr_q;

    if (hs) begin
      if (!last_q) begin
        adr_d   = nxt_adr_q;
        sel_d   = hi_sel_q;
        dat_d   = hi_dat_q;
        seq_d   = 1'b1;
        last_d  = 1'b1;
        state_d = SECOND;
      end else begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    end

    if (accept) begin
      if (size_ok) begin
        valid_d   = 1'b1;
        we_d      = bus_if.req_we_i;
        adr_d     = base_adr;
        sel_d     = mask2[BUS_BYTES-1:0];
        dat_d     = dat2[DW-1:0];
        last_d    = (mask2[SW-1:BUS_BYTES] == '0);
        seq_d     = 1'b0;
        hi_sel_d  = mask2[SW-1:BUS_BYTES];
        hi_dat_d  = dat2[W2-1:DW];
        nxt_adr_d = base_adr + AWID'(BUS_BYTES);
        state_d   = FIRST;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      sel_q     <= '0;
      dat_q     <= '0;
      last_q    <= 1'b0;
      seq_q     <= 1'b0;
      err_q     <= 1'b0;
      hi_sel_q  <= '0;
      hi_dat_q  <= '0;
      nxt_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      sel_q     <= sel_d;
      dat_q     <= dat_d;
      last_q    <= last_d;
      seq_q     <= seq_d;
      err_q     <= err_d;
      hi_sel_q  <= hi_sel_d;
      hi_dat_q  <= hi_dat_d;
      nxt_adr_q <= nxt_adr_d;
    end
  end

  assign bus_if.req_ready_o = req_ready;
  assign bus_if.bus_valid_o = valid_q;
  assign bus_if.bus_we_o    = we_q;
  assign bus_if.bus_adr_o   = adr_q;
  assign bus_if.bus_sel_o   = sel_q;
  assign bus_if.bus_dat_o   = dat_q;
  assign bus_if.bus_last_o  = last_q;
  assign bus_if.bus_seq_o   = seq_q;
  assign bus_if.err_o       = err_q;

endmodule

// File: tb/tb_any1_sel_align.sv
// Directed bench for any1_sel_align with a scoreboard of expected bus cycles.
module tb_any1_sel_align;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  typedef struct {
    logic         we;
    logic [31:0]  adr;
    logic [15:0]  sel;
    logic [127:0] dat;
    logic         last;
    logic         seq;
  } exp_t;

  exp_t sb[$];

  any1_sel_align_if #(.AWID(32), .BUS_BYTES(16)) bif ();

  any1_sel_align #(.AWID(32), .BUS_BYTES(16), .MAX_SIZE(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_if (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic we, input logic [31:0] adr, input logic [15:0] sel,
                               input logic [127:0] dat, input logic last, input logic seq);
    exp_t e;
    e.we = we; e.adr = adr; e.sel = sel; e.dat = dat; e.last = last; e.seq = seq;
    sb.push_back(e);
  endfunction

  // Every completed bus handshake must match the oldest expected cycle.
  always @(negedge clk) begin
    if (rst_n && bif.bus_valid_o && bif.bus_ready_i) begin
      chk("sb_nonempty", (sb.size() != 0), 1'b1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("bus_we",   bif.bus_we_o,   e.we);
        chk("bus_adr",  bif.bus_adr_o,  e.adr);
        chk("bus_sel",  bif.bus_sel_o,  e.sel);
        chk("bus_dat",  bif.bus_dat_o,  e.dat);
        chk("bus_last", bif.bus_last_o, e.last);
        chk("bus_seq",  bif.bus_seq_o,  e.seq);
      end
    end
  end

  // Present one request and hold it until accepted; returns just after the accept edge.
  task automatic drive_req(input logic we, input logic [31:0] adr, input logic [2:0] size,
                           input logic [127:0] dat);
    bit got;
    got = 1'b0;
    bif.req_valid_i = 1'b1;
    bif.req_we_i    = we;
    bif.req_adr_i   = adr;
    bif.req_size_i  = size;
    bif.req_dat_i   = dat;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bif.req_ready_o) got = 1'b1;
      @(posedge clk); #1;
    end
    bif.req_valid_i = 1'b0;
    chk("req_accept", got, 1'b1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, bif.bus_valid_o, 1'b0);
    chk({tag, "_we"},    bif.bus_we_o,    1'b0);
    chk({tag, "_adr"},   bif.bus_adr_o,   32'h0);
    chk({tag, "_sel"},   bif.bus_sel_o,   16'h0);
    chk({tag, "_dat"},   bif.bus_dat_o,   128'h0);
    chk({tag, "_last"},  bif.bus_last_o,  1'b0);
    chk({tag, "_seq"},   bif.bus_seq_o,   1'b0);
    chk({tag, "_err"},   bif.err_o,       1'b0);
  endtask

  initial begin
    int c0;
    rst_n           = 1'b0;
    bif.req_valid_i = 1'b0;
    bif.req_we_i    = 1'b0;
    bif.req_adr_i   = '0;
    bif.req_size_i  = '0;
    bif.req_dat_i   = '0;
    bif.bus_ready_i = 1'b1;

    #12;
    chk_idle_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_ready", bif.req_ready_o, 1'b1);

    // Single-cycle load inside one bus word.
    push(1'b0, 32'h1000, 16'h00F0, 128'h0, 1'b1, 1'b0);
    drive_req(1'b0, 32'h1004, 3'd2, 128'h0);
    chk("ld_lat_valid", bif.bus_valid_o, 1'b1);
    @(posedge clk); #1;
    chk("ld_drop_valid", bif.bus_valid_o, 1'b0);

    // Split store; upper request bytes beyond the size must be dropped.
    push(1'b1, 32'h1000, 16'hF000, {32'h44332211, 96'h0}, 1'b0, 1'b0);
    push(1'b1, 32'h1010, 16'h000F, 128'h88776655, 1'b1, 1'b1);
    drive_req(1'b1, 32'h100C, 3'd3, {64'hDEADBEEF_CAFEF00D, 64'h88776655_44332211});
    chk("split_c1_valid", bif.bus_valid_o, 1'b1);
    chk("split_c1_seq",   bif.bus_seq_o,   1'b0);
    @(posedge clk); #1;
    chk("split_c2_valid", bif.bus_valid_o, 1'b1);
    chk("split_c2_seq",   bif.bus_seq_o,   1'b1);
    @(posedge clk); #1;
    chk("split_drop", bif.bus_valid_o, 1'b0);

    // Address wrap on the second half.
    push(1'b1, 32'hFFFF_FFF0, 16'hC000, {16'hCCDD, 112'h0}, 1'b0, 1'b0);
    push(1'b1, 32'h0000_0000, 16'h0003, 128'hAABB, 1'b1, 1'b1);
    drive_req(1'b1, 32'hFFFF_FFFE, 3'd2, 128'hAABBCCDD);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wrap_drop", bif.bus_valid_o, 1'b0);

    // Full-width aligned store never splits.
    push(1'b1, 32'h5000, 16'hFFFF, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1, 1'b0);
    drive_req(1'b1, 32'h5000, 3'd4, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("full_last", bif.bus_last_o, 1'b1);
    @(posedge clk); #1;
    chk("full_drop", bif.bus_valid_o, 1'b0);

    // Back-pressure on both halves of a split.
    bif.bus_ready_i = 1'b0;
    push(1'b1, 32'h2010, 16'hC000, {16'h3344, 112'h0}, 1'b0, 1'b0);
    push(1'b1, 32'h2020, 16'h0003, 128'h1122, 1'b1, 1'b1);
    drive_req(1'b1, 32'h201E, 3'd2, 128'h11223344);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall1_valid", bif.bus_valid_o, 1'b1);
      chk("stall1_adr",   bif.bus_adr_o,   32'h2010);
      chk("stall1_sel",   bif.bus_sel_o,   16'hC000);
      chk("stall1_dat",   bif.bus_dat_o,   {16'h3344, 112'h0});
      chk("stall1_seq",   bif.bus_seq_o,   1'b0);
      chk("stall1_ready", bif.req_ready_o, 1'b0);
      @(posedge clk); #1;
    end
    bif.bus_ready_i = 1'b1;
    @(negedge clk);
    chk("hs1_req_ready", bif.req_ready_o, 1'b0);
    @(posedge clk); #1;
    bif.bus_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall2_valid", bif.bus_valid_o, 1'b1);
      chk("stall2_adr",   bif.bus_adr_o,   32'h2020);
      chk("stall2_sel",   bif.bus_sel_o,   16'h0003);
      chk("stall2_dat",   bif.bus_dat_o,   128'h1122);
      chk("stall2_last",  bif.bus_last_o,  1'b1);
      chk("stall2_ready", bif.req_ready_o, 1'b0);
      @(posedge clk); #1;
    end
    bif.bus_ready_i = 1'b1;
    @(negedge clk);
    chk("hs2_req_ready", bif.req_ready_o, 1'b1);
    @(posedge clk); #1;
    chk("stall_drop", bif.bus_valid_o, 1'b0);

    // Illegal size: accepted, one-cycle error, no bus cycle.
    drive_req(1'b0, 32'h3000, 3'd5, 128'h0);
    chk("ill_err_hi", bif.err_o,       1'b1);
    chk("ill_valid",  bif.bus_valid_o, 1'b0);
    @(posedge clk); #1;
    chk("ill_err_lo", bif.err_o,       1'b0);
    chk("ill_valid2", bif.bus_valid_o, 1'b0);

    // Back-to-back byte loads, one per clock.
    for (int i = 0; i < 4; i++) begin
      logic [127:0] d;
      d = 128'hA5;
      push(1'b0, 32'h0, 16'(1 << i), d << (8 * i), 1'b1, 1'b0);
    end
    c0 = cyc;
    for (int i = 0; i < 4; i++) drive_req(1'b0, 32'(i), 3'd0, 128'hFFFF_FFA5);
    chk("b2b_cycles", 32'(cyc - c0), 32'd4);
    chk("b2b_valid",  bif.bus_valid_o, 1'b1);
    @(posedge clk); #1;
    chk("b2b_drop", bif.bus_valid_o, 1'b0);

    // Reset during the first half of a split drops the second half.
    bif.bus_ready_i = 1'b0;
    drive_req(1'b1, 32'h400E, 3'd2, 128'h01020304);
    chk("mid_valid", bif.bus_valid_o, 1'b1);
    chk("mid_last",  bif.bus_last_o,  1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bif.bus_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle_outputs("post_rst");
      chk("post_rst_ready", bif.req_ready_o, 1'b1);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
